// File: rtl/isqrt_share_arbiter.sv
// Round-robin share of one pipelined isqrt between N_REQ requesters.
// An in-order tag FIFO routes each result back to the requester that issued it.
module isqrt_share_arbiter #(
    parameter int N_REQ     = 2,
    parameter int TAG_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [32*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]   req_rdy,
    output logic [N_REQ-1:0]   rsp_vld,
    output logic [15:0]        rsp_y,
    output logic               isqrt_x_vld,
    output logic [31:0]        isqrt_x,
    input  logic               isqrt_y_vld,
    input  logic [15:0]        isqrt_y,
    output logic               tag_err
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [TAG_W-1:0] LAST_ID = TAG_W'(N_REQ - 1);

    logic [TAG_W-1:0] rr;
    logic [TAG_W-1:0] gnt_id;
    logic [TAG_W-1:0] idx;
    logic             grant;
    logic [31:0]      x_arr [N_REQ];
    logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             pop;
    logic [TAG_W-1:0] head;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign pop   = isqrt_y_vld & ~empty;
    assign head  = tag_mem[rd_ptr];

    // Split the flat operand bus into one word per requester
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = req_x[32*i +: 32];
        end
    end

    // Round-robin search starting at rr; nothing is granted while the FIFO is full
    always_comb begin
        req_rdy = '0;
        grant   = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        if (!full) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = TAG_W'((int'(rr) + k) % N_REQ);
                if (!grant && req_vld[idx]) begin
                    grant        = 1'b1;
                    gnt_id       = idx;
                    req_rdy[idx] = 1'b1;
                end
            end
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr] <= gnt_id;
        end
    end

    // Issue register, FIFO pointers, response routing and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            isqrt_x_vld <= 1'b0;
            isqrt_x     <= '0;
            rsp_vld     <= '0;
            rsp_y       <= '0;
            tag_err     <= 1'b0;
        end else begin
            isqrt_x_vld <= grant;
            if (grant) begin
                isqrt_x <= x_arr[gnt_id];
                wr_ptr  <= wr_ptr + 1'b1;
                rr      <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rsp_y  <= isqrt_y;
            end
            if (grant && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !grant) begin
                count <= count - 1'b1;
            end
            rsp_vld <= pop ? (N_REQ'(1) << head) : '0;
            if (isqrt_y_vld && empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Directed bench for isqrt_share_arbiter with a 16-stage isqrt model.
// The model can be bypassed so the bench drives isqrt results by hand.
module tb_isqrt_share_arbiter;

    localparam int LAT = 16;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_vld;
    logic [63:0] req_x;
    logic [1:0]  req_rdy;
    logic [1:0]  rsp_vld;
    logic [15:0] rsp_y;
    logic        isqrt_x_vld;
    logic [31:0] isqrt_x;
    logic        isqrt_y_vld;
    logic [15:0] isqrt_y;
    logic        tag_err;

    logic        model_en;
    logic        man_vld;
    logic [15:0] man_y;
    logic        pv [LAT];
    logic [15:0] py [LAT];

    int checks;
    int errors;

    isqrt_share_arbiter #(.N_REQ(2), .TAG_DEPTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .tag_err     (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] isq(input logic [31:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    // Fixed-latency isqrt model sharing the DUT reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                py[i] <= 16'd0;
            end
        end else begin
            pv[0] <= isqrt_x_vld;
            py[0] <= isq(isqrt_x);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign isqrt_y_vld = model_en ? pv[LAT-1] : man_vld;
    assign isqrt_y     = model_en ? py[LAT-1] : man_y;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_vld  = 2'b00;
        req_x    = 64'd0;
        man_vld  = 1'b0;
        man_y    = 16'd0;
        model_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (isqrt_x_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_x_vld got %b want 0", isqrt_x_vld);
        end
        checks++;
        if (isqrt_x !== 32'd0) begin
            errors++;
            $display("FAIL reset_x got %0d want 0", isqrt_x);
        end
        checks++;
        if (rsp_vld !== 2'b00 || rsp_y !== 16'd0) begin
            errors++;
            $display("FAIL reset_rsp got %b/%0d want 00/0", rsp_vld, rsp_y);
        end
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_tag_err got %b want 0", tag_err);
        end
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL reset_rdy_idle got %b want 00", req_rdy);
        end
        req_vld = 2'b10;
        #1;
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++;
            $display("FAIL reset_rdy_req1 got %b want 10", req_rdy);
        end
        req_vld = 2'b00;
    endtask

    task automatic test_single();
        do_reset();
        req_x[31:0] = 32'd144;
        req_vld     = 2'b01;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL single_rdy got %b want 01", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        checks++;
        if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd144) begin
            errors++;
            $display("FAIL single_issue got %b/%0d want 1/144", isqrt_x_vld, isqrt_x);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (rsp_vld !== 2'b00) begin
                errors++;
                $display("FAIL single_early_rsp c%0d got %b want 00", c, rsp_vld);
            end
        end
        tick();
        checks++;
        if (rsp_vld !== 2'b01 || rsp_y !== 16'd12) begin
            errors++;
            $display("FAIL single_rsp got %b/%0d want 01/12", rsp_vld, rsp_y);
        end
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL single_tag_err got %b want 0", tag_err);
        end
        tick();
        checks++;
        if (rsp_vld !== 2'b00 || rsp_y !== 16'd12) begin
            errors++;
            $display("FAIL single_after got %b/%0d want 00/12", rsp_vld, rsp_y);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  er;
        logic [31:0] ex;
        logic [15:0] ey;
        do_reset();
        req_x   = {32'd49, 32'd100};
        req_vld = 2'b11;
        for (int i = 0; i < 8; i++) begin
            er = (i % 2 == 0) ? 2'b01 : 2'b10;
            ex = (i % 2 == 0) ? 32'd100 : 32'd49;
            #1;
            checks++;
            if (req_rdy !== er) begin
                errors++;
                $display("FAIL contend_rdy i%0d got %b want %b", i, req_rdy, er);
            end
            tick();
            checks++;
            if (isqrt_x_vld !== 1'b1 || isqrt_x !== ex) begin
                errors++;
                $display("FAIL contend_issue i%0d got %b/%0d want 1/%0d",
                         i, isqrt_x_vld, isqrt_x, ex);
            end
        end
        req_vld = 2'b00;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            er = (i % 2 == 0) ? 2'b01 : 2'b10;
            ey = (i % 2 == 0) ? 16'd10 : 16'd7;
            checks++;
            if (rsp_vld !== er || rsp_y !== ey) begin
                errors++;
                $display("FAIL contend_rsp i%0d got %b/%0d want %b/%0d",
                         i, rsp_vld, rsp_y, er, ey);
            end
            tick();
        end
        checks++;
        if (rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL contend_drain got %b want 00", rsp_vld);
        end
    endtask

    task automatic test_full();
        logic [1:0] er;
        do_reset();
        model_en = 1'b0;
        req_x    = {32'd49, 32'd100};
        req_vld  = 2'b11;
        for (int i = 0; i < 32; i++) begin
            er = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (req_rdy !== er) begin
                errors++;
                $display("FAIL full_fill_rdy i%0d got %b want %b", i, req_rdy, er);
            end
            tick();
        end
        #1;
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL full_rdy got %b want 00", req_rdy);
        end
        tick();
        checks++;
        if (req_rdy !== 2'b00 || isqrt_x_vld !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got %b/%b want 00/0", req_rdy, isqrt_x_vld);
        end
        man_y   = 16'd5;
        man_vld = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL full_no_bypass got %b want 00", req_rdy);
        end
        tick();
        man_vld = 1'b0;
        #1;
        checks++;
        if (rsp_vld !== 2'b01 || rsp_y !== 16'd5) begin
            errors++;
            $display("FAIL full_pop_rsp got %b/%0d want 01/5", rsp_vld, rsp_y);
        end
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL full_regrant got %b want 01", req_rdy);
        end
        tick();
        checks++;
        if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd100) begin
            errors++;
            $display("FAIL full_regrant_issue got %b/%0d want 1/100", isqrt_x_vld, isqrt_x);
        end
        #1;
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL full_again got %b want 00", req_rdy);
        end
        req_vld = 2'b00;
    endtask

    task automatic test_push_pop();
        do_reset();
        model_en = 1'b0;
        req_x    = {32'd49, 32'd100};
        req_vld  = 2'b11;
        repeat (31) tick();
        #1;
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++;
            $display("FAIL pp_rdy31 got %b want 10", req_rdy);
        end
        man_y   = 16'd9;
        man_vld = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++;
            $display("FAIL pp_rdy_pop got %b want 10", req_rdy);
        end
        tick();
        man_vld = 1'b0;
        checks++;
        if (rsp_vld !== 2'b01 || rsp_y !== 16'd9) begin
            errors++;
            $display("FAIL pp_rsp_oldest got %b/%0d want 01/9", rsp_vld, rsp_y);
        end
        checks++;
        if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd49) begin
            errors++;
            $display("FAIL pp_issue got %b/%0d want 1/49", isqrt_x_vld, isqrt_x);
        end
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL pp_count31 got %b want 01", req_rdy);
        end
        tick();
        #1;
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL pp_full got %b want 00", req_rdy);
        end
        req_vld = 2'b00;
        man_y   = 16'd8;
        man_vld = 1'b1;
        tick();
        man_vld = 1'b0;
        checks++;
        if (rsp_vld !== 2'b10 || rsp_y !== 16'd8) begin
            errors++;
            $display("FAIL pp_rsp_second got %b/%0d want 10/8", rsp_vld, rsp_y);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        model_en = 1'b0;
        man_y    = 16'd3;
        man_vld  = 1'b1;
        tick();
        man_vld = 1'b0;
        checks++;
        if (rsp_vld !== 2'b00 || rsp_y !== 16'd0) begin
            errors++;
            $display("FAIL spur_drop got %b/%0d want 00/0", rsp_vld, rsp_y);
        end
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL spur_tag_err got %b want 1", tag_err);
        end
        model_en     = 1'b1;
        req_x[63:32] = 32'd49;
        req_vld      = 2'b10;
        #1;
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++;
            $display("FAIL spur_rdy got %b want 10", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        repeat (17) tick();
        checks++;
        if (rsp_vld !== 2'b10 || rsp_y !== 16'd7) begin
            errors++;
            $display("FAIL spur_traffic got %b/%0d want 10/7", rsp_vld, rsp_y);
        end
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky got %b want 1", tag_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        model_en = 1'b0;
        man_y    = 16'd3;
        man_vld  = 1'b1;
        tick();
        man_vld = 1'b0;
        req_x   = {32'd49, 32'd100};
        req_vld = 2'b11;
        repeat (3) tick();
        man_y   = 16'd4;
        man_vld = 1'b1;
        tick();
        man_vld = 1'b0;
        req_vld = 2'b00;
        checks++;
        if (isqrt_x_vld !== 1'b1 || rsp_vld !== 2'b01 || rsp_y !== 16'd4 || tag_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got %b/%b/%0d/%b want 1/01/4/1",
                     isqrt_x_vld, rsp_vld, rsp_y, tag_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0) begin
            errors++;
            $display("FAIL mid_async_issue got %b/%0d want 0/0", isqrt_x_vld, isqrt_x);
        end
        checks++;
        if (rsp_vld !== 2'b00 || rsp_y !== 16'd0) begin
            errors++;
            $display("FAIL mid_async_rsp got %b/%0d want 00/0", rsp_vld, rsp_y);
        end
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_tag_err got %b want 0", tag_err);
        end
        tick();
        rst_n       = 1'b1;
        model_en    = 1'b1;
        req_x[31:0] = 32'd0;
        req_vld     = 2'b01;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL mid_post_rdy got %b want 01", req_rdy);
        end
        tick();
        req_vld = 2'b00;
        repeat (17) tick();
        checks++;
        if (rsp_vld !== 2'b01 || rsp_y !== 16'd0) begin
            errors++;
            $display("FAIL mid_post_rsp got %b/%0d want 01/0", rsp_vld, rsp_y);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req_vld  = 2'b00;
        req_x    = 64'd0;
        model_en = 1'b1;
        man_vld  = 1'b0;
        man_y    = 16'd0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_push_pop();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/isqrt_share_arbiter.md
Name: isqrt_share_arbiter

Overview:
Shares one pipelined isqrt instance between N_REQ independent requesters, such as several formula FSMs.
- Grants one request per cycle using round-robin priority.
- Drives the isqrt input port.
- Records the owner of each issued operation in an in-order tag FIFO.
- Routes each isqrt result back to its owner.
- Sits between the formula FSMs and the single isqrt instance at the top level.

Parameters:
N_REQ, 2, number of requesters (2..8).
TAG_DEPTH, 32, tag FIFO entries; must be >= isqrt pipeline depth + 2 for full throughput (power of 2).
TAG_W, $clog2(N_REQ), requester id width (internal, derived).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
req_vld  in  N_REQ  per-requester operand valid
req_x  in  32*N_REQ  operands; requester i uses bits [32*i+31:32*i]
req_rdy  out  N_REQ  per-requester accept; one-hot or zero
rsp_vld  out  N_REQ  per-requester result valid; one-hot or zero
rsp_y  out  16  result, shared by all requesters, qualified by rsp_vld
isqrt_x_vld  out  1  to isqrt
isqrt_x  out  32  to isqrt
isqrt_y_vld  in  1  from isqrt
isqrt_y  in  16  from isqrt
tag_err  out  1  sticky: isqrt result arrived with an empty tag FIFO

Behaviour:
- Decided interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: isqrt_x_vld=0, isqrt_x=0, rsp_vld=0, rsp_y=0, tag_err=0, FIFO empty (count=0, pointers=0), round-robin pointer rr=0.
- The isqrt instance shares rst_n, so no stale results survive reset.
- Handshake: a transfer happens when req_vld[i] & req_rdy[i].
  - A requester holds req_vld and req_x stable until accepted.
  - req_rdy is combinational from req_vld, rr and FIFO count.
- Arbitration:
  - If count == TAG_DEPTH, all req_rdy are 0. No bypass of a simultaneous pop.
  - Otherwise req_rdy[g]=1 for the first i with req_vld[i]=1, searching from rr upward and wrapping modulo N_REQ.
  - After a grant to g, rr <= (g+1) mod N_REQ. With no grant, rr holds.
- Issue, registered:
  - Grant in cycle t gives isqrt_x_vld=1 and isqrt_x=req_x[g] in cycle t+1.
  - Push g into the FIFO at the same clock edge.
  - With no grant, isqrt_x_vld=0 and isqrt_x holds its last value.
- Return:
  - isqrt_y_vld=1 with FIFO non-empty pops head tag h.
  - Next cycle: rsp_vld[h]=1 and rsp_y=isqrt_y. Other bits of rsp_vld are 0.
  - With no isqrt_y_vld, rsp_vld=0 and rsp_y holds.
  - End-to-end latency = isqrt latency + 2 cycles from acceptance.
- Ordering: results return in acceptance order; the isqrt is in-order and never stalls. There is no backpressure on rsp_vld, so requesters must always accept results.
- Simultaneous push and pop: count unchanged, both pointers advance. The pop uses the old head.
- Boundaries:
  - isqrt_y_vld with an empty FIFO: the result is dropped, rsp_vld stays 0, tag_err <= 1 until reset.
  - Pointer wrap is modulo TAG_DEPTH.
  - Count never exceeds TAG_DEPTH.
- Reset mid-operation: in-flight tags are discarded and all outputs return to reset values immediately, because the reset is asynchronous.

Test Plan:
1. Single requester. N_REQ=2, isqrt latency 16; req 0 sends x=144 at cycle 10 -> isqrt_x_vld at 11 with x=144; rsp_vld=2'b01 and rsp_y=12 at cycle 28; tag_err=0.
2. Contention. Both requesters hold vld continuously with x0=100 and x1=49 -> grants alternate 0,1,0,1 every cycle. Responses alternate 2'b01 (y=10) and 2'b10 (y=7) back-to-back at full rate.
3. Full FIFO. TAG_DEPTH=4 with a stub isqrt that holds results -> after 4 accepts req_rdy=0. One isqrt_y_vld re-enables exactly one grant on the following cycle.
4. Simultaneous push/pop at count=TAG_DEPTH-1 -> count stays TAG_DEPTH-1, and the response goes to the correct (oldest) owner.
5. Spurious isqrt_y_vld=1 after reset with an empty FIFO -> rsp_vld stays 0, tag_err=1, and it remains 1 through later normal traffic.
6. Assert rst_n=0 mid-burst with 3 tags in flight -> isqrt_x_vld, rsp_vld and tag_err go to 0 without waiting for a clock edge. After release, a new request to x=0 returns y=0 to the correct requester.
